// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared types and bit-counting helpers for the multi-ported free list
package free_list_pkg;

    // Widest strobe vector the helpers accept; callers zero-extend into it.
    localparam int FL_MAX_PORTS = 16;

    // Pointer type for the default 64-slot free list: slot index plus one wrap bit.
    localparam int FL_DEFAULT_DEPTH = 64;
    typedef logic [$clog2(FL_DEFAULT_DEPTH):0] fl_ptr_t;

    // Number of set bits in a strobe vector.
    function automatic int unsigned fl_popcount(input logic [FL_MAX_PORTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < FL_MAX_PORTS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Count of set bits strictly below bit k: the compacted write offset of port k.
    function automatic int unsigned fl_prefix_count(input logic [FL_MAX_PORTS-1:0] v,
                                                    input int k);
        int unsigned n;
        n = 0;
        for (int i = 0; i < FL_MAX_PORTS; i++) begin
            if (i < k && v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/free_list_mp_dec.sv
// rtl/free_list_mp_dec.sv - binary slot index to one-hot slot select
module fl_onehot_dec #(
    parameter int SW = 6,
    parameter int N  = 64
) (
    input  logic [SW-1:0] idx,
    input  logic          en,
    output logic [N-1:0]  sel
);

    // Raise exactly one select line when enabled, none otherwise.
    always_comb begin
        sel = '0;
        if (en) sel[idx] = 1'b1;
    end

endmodule

// File: rtl/free_list_mp.sv
// rtl/free_list_mp.sv - multi-ported preloaded circular free list (optional checkpoint: FREE_LIST_MP_CKPT_EN)
module free_list_mp
    import free_list_pkg::*;
#(
    parameter int DW         = 7,
    parameter int DEPTH      = 64,
    parameter int PUSH_PORTS = 2,
    parameter int POP_PORTS  = 2,
    parameter int INIT_BASE  = 32,
    parameter int INIT_COUNT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PUSH_PORTS-1:0]    push,
    input  logic [PUSH_PORTS*DW-1:0] push_data,
    output logic                     ready,
    input  logic [POP_PORTS-1:0]     pop,
    output logic [POP_PORTS*DW-1:0]  pop_data,
    output logic [POP_PORTS-1:0]     valid,
    output logic [$clog2(DEPTH):0]   count
`ifdef FREE_LIST_MP_CKPT_EN
    ,
    input  logic                     ckpt_save,
    input  logic                     ckpt_restore
`endif
);

    localparam int SW = $clog2(DEPTH);
    localparam int PW = SW + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_next;
    logic [PW-1:0]    tail_next;
    logic [PW-1:0]    npop;
    logic [PW-1:0]    npush;
    logic [DEPTH-1:0] rd_sel [POP_PORTS];
    logic [DEPTH-1:0] wr_sel [PUSH_PORTS];

    assign npop  = PW'(fl_popcount(FL_MAX_PORTS'(pop)));
    assign npush = PW'(fl_popcount(FL_MAX_PORTS'(push)));

    // Pop port p always looks at slot head+p; pop strobes only move the head.
    for (genvar p = 0; p < POP_PORTS; p++) begin : g_rd
        logic [SW-1:0] rd_idx;
        assign rd_idx = head[SW-1:0] + SW'(p);
        fl_onehot_dec #(.SW(SW), .N(DEPTH)) u_rd_dec (
            .idx (rd_idx),
            .en  (1'b1),
            .sel (rd_sel[p])
        );
    end

    // Active pushes are packed in port order starting at the tail slot.
    for (genvar k = 0; k < PUSH_PORTS; k++) begin : g_wr
        logic [SW-1:0] wr_idx;
        assign wr_idx = tail[SW-1:0] + SW'(fl_prefix_count(FL_MAX_PORTS'(push), k));
        fl_onehot_dec #(.SW(SW), .N(DEPTH)) u_wr_dec (
            .idx (wr_idx),
            .en  (push[k]),
            .sel (wr_sel[k])
        );
    end

    // Shared AND-OR mux: each pop port ORs the slot picked by its one-hot select.
    always_comb begin
        pop_data = '0;
        for (int p = 0; p < POP_PORTS; p++) begin
            for (int j = 0; j < DEPTH; j++) begin
                pop_data[p*DW +: DW] |= mem[j] & {DW{rd_sel[p][j]}};
            end
        end
    end

    // Slot storage: preloaded with consecutive identifiers, written by compacted pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= DW'(INIT_BASE + j);
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                for (int k = 0; k < PUSH_PORTS; k++) begin
                    if (wr_sel[k][j]) mem[j] <= push_data[k*DW +: DW];
                end
            end
        end
    end

`ifdef FREE_LIST_MP_CKPT_EN
    logic [PW-1:0] ckpt_head;
`endif

    // Next pointers; a checkpoint restore overrides the head advance.
    always_comb begin
        head_next = head + npop;
        tail_next = tail + npush;
`ifdef FREE_LIST_MP_CKPT_EN
        if (ckpt_restore) head_next = ckpt_head;
`endif
    end

    // Head and tail registers; tail starts past the preloaded identifiers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= PW'(INIT_COUNT);
        end else begin
            head <= head_next;
            tail <= tail_next;
        end
    end

`ifdef FREE_LIST_MP_CKPT_EN
    // Checkpoint capture of the post-pop head; a simultaneous restore blocks the save.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ckpt_head <= '0;
        end else if (ckpt_save && !ckpt_restore) begin
            ckpt_head <= head_next;
        end
    end
`endif

    assign count = tail - head;
    assign ready = (count <= PW'(DEPTH - PUSH_PORTS));

    // Port i has an identifier to offer when more than i slots are occupied.
    always_comb begin
        valid = '0;
        for (int i = 0; i < POP_PORTS; i++) begin
            valid[i] = (count > PW'(i));
        end
    end

    logic [POP_PORTS-1:0] pop_inc;
    assign pop_inc = pop + 1'b1;

    a_push_ready: assert property (@(posedge clk) disable iff (rst) (|push) |-> ready)
        else $fatal(1, "push while not ready");
    a_pop_valid: assert property (@(posedge clk) disable iff (rst) (pop & ~valid) == '0)
        else $fatal(1, "pop on an invalid port");
    a_pop_thermo: assert property (@(posedge clk) disable iff (rst) (pop & pop_inc) == '0)
        else $fatal(1, "pop is not thermometer coded");
`ifdef FREE_LIST_MP_CKPT_EN
    a_restore_nopop: assert property (@(posedge clk) disable iff (rst) ckpt_restore |-> (pop == '0))
        else $fatal(1, "pop during checkpoint restore");
`endif

endmodule

// File: tb/tb_free_list_mp.sv
// tb/tb_free_list_mp.sv - directed self-checking bench for free_list_mp
module tb_free_list_mp;

    localparam int DW = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  push;
    logic [13:0] push_data;
    logic        ready;
    logic [1:0]  pop;
    logic [13:0] pop_data;
    logic [1:0]  valid;
    logic [6:0]  count;
`ifdef FREE_LIST_MP_CKPT_EN
    logic        ckpt_save;
    logic        ckpt_restore;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    free_list_mp #(
        .DW(DW), .DEPTH(64), .PUSH_PORTS(2), .POP_PORTS(2), .INIT_BASE(32), .INIT_COUNT(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .ready     (ready),
        .pop       (pop),
        .pop_data  (pop_data),
        .valid     (valid),
        .count     (count)
`ifdef FREE_LIST_MP_CKPT_EN
        ,
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = '0; pop = '0; push_data = '0;
`ifdef FREE_LIST_MP_CKPT_EN
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL reset_count got %0d want 32", count); end
        checks++; if (pop_data[6:0] !== 7'd32) begin errors++; $display("FAIL reset_pd0 got %0d want 32", pop_data[6:0]); end
        checks++; if (pop_data[13:7] !== 7'd33) begin errors++; $display("FAIL reset_pd1 got %0d want 33", pop_data[13:7]); end
        checks++; if (valid !== 2'b11) begin errors++; $display("FAIL reset_valid got %b want 11", valid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    endtask

    task automatic test_pop_drain();
        pop = 2'b11;
        for (int c = 0; c < 16; c++) begin
            checks++; if (pop_data[6:0] !== 7'(32 + 2*c)) begin errors++; $display("FAIL drain_pd0 c=%0d got %0d want %0d", c, pop_data[6:0], 32 + 2*c); end
            checks++; if (pop_data[13:7] !== 7'(33 + 2*c)) begin errors++; $display("FAIL drain_pd1 c=%0d got %0d want %0d", c, pop_data[13:7], 33 + 2*c); end
            step();
        end
        pop = '0;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
        checks++; if (valid !== 2'b00) begin errors++; $display("FAIL drain_valid got %b want 00", valid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", ready); end
    endtask

    task automatic test_no_bypass();
        push = 2'b01; push_data = {7'd0, 7'd7};
        #1;
        checks++; if (valid !== 2'b00) begin errors++; $display("FAIL nobypass_valid_t got %b want 00", valid); end
        step();
        push = '0;
        checks++; if (valid !== 2'b01) begin errors++; $display("FAIL nobypass_valid_t1 got %b want 01", valid); end
        checks++; if (count !== 7'd1) begin errors++; $display("FAIL nobypass_count got %0d want 1", count); end
        checks++; if (pop_data[6:0] !== 7'd7) begin errors++; $display("FAIL nobypass_pd0 got %0d want 7", pop_data[6:0]); end
    endtask

    task automatic test_push_port1();
        push = 2'b10; push_data = {7'd9, 7'd5}; pop = 2'b01;
        step();
        push = '0; pop = '0;
        checks++; if (count !== 7'd1) begin errors++; $display("FAIL port1_count got %0d want 1", count); end
        checks++; if (pop_data[6:0] !== 7'd9) begin errors++; $display("FAIL port1_pd0 got %0d want 9", pop_data[6:0]); end
        checks++; if (pop_data[13:7] !== 7'd66) begin errors++; $display("FAIL port1_pd1 got %0d want 66", pop_data[13:7]); end
        checks++; if (valid !== 2'b01) begin errors++; $display("FAIL port1_valid got %b want 01", valid); end
        pop = 2'b01;
        step();
        pop = '0;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL port1_empty got %0d want 0", count); end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 31; c++) begin
            push = 2'b11; push_data = {7'(2*c + 1), 7'(2*c)};
            step();
        end
        push = '0;
        checks++; if (count !== 7'd62) begin errors++; $display("FAIL fill_count62 got %0d want 62", count); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fill_ready62 got %b want 1", ready); end
        push = 2'b01; push_data = {7'd0, 7'd62};
        step();
        push = '0;
        checks++; if (count !== 7'd63) begin errors++; $display("FAIL fill_count63 got %0d want 63", count); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fill_ready63 got %b want 0", ready); end
        checks++; if (valid !== 2'b11) begin errors++; $display("FAIL fill_valid got %b want 11", valid); end
    endtask

    task automatic test_wrap();
        int n;
        pop = 2'b11;
        for (int c = 0; c < 11; c++) begin
            checks++; if (pop_data[6:0] !== 7'(2*c)) begin errors++; $display("FAIL wrap_pd0 c=%0d got %0d want %0d", c, pop_data[6:0], 2*c); end
            checks++; if (pop_data[13:7] !== 7'(2*c + 1)) begin errors++; $display("FAIL wrap_pd1 c=%0d got %0d want %0d", c, pop_data[13:7], 2*c + 1); end
            step();
        end
        pop = 2'b01;
        checks++; if (pop_data[6:0] !== 7'd22) begin errors++; $display("FAIL wrap_pd0_22 got %0d want 22", pop_data[6:0]); end
        step();
        pop = '0;
        checks++; if (count !== 7'd40) begin errors++; $display("FAIL wrap_count40 got %0d want 40", count); end
        for (int c = 0; c < 10; c++) begin
            pop = 2'b01; push = 2'b01; push_data = {7'd0, 7'(100 + c)};
            checks++; if (pop_data[6:0] !== 7'(23 + c)) begin errors++; $display("FAIL steady_pd0 c=%0d got %0d want %0d", c, pop_data[6:0], 23 + c); end
            step();
            checks++; if (count !== 7'd40) begin errors++; $display("FAIL steady_count c=%0d got %0d want 40", c, count); end
        end
        pop = 2'b11; push = '0;
        for (int c = 0; c < 20; c++) begin
            n = 2*c;
            checks++; if (pop_data[6:0] !== 7'(n < 30 ? 33 + n : 70 + n)) begin errors++; $display("FAIL tail_pd0 n=%0d got %0d want %0d", n, pop_data[6:0], n < 30 ? 33 + n : 70 + n); end
            checks++; if (pop_data[13:7] !== 7'(n + 1 < 30 ? 34 + n : 71 + n)) begin errors++; $display("FAIL tail_pd1 n=%0d got %0d want %0d", n, pop_data[13:7], n + 1 < 30 ? 34 + n : 71 + n); end
            step();
        end
        pop = '0;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL tail_count got %0d want 0", count); end
        checks++; if (valid !== 2'b00) begin errors++; $display("FAIL tail_valid got %b want 00", valid); end
    endtask

    task automatic test_mid_reset();
        push = 2'b11; push_data = {7'd3, 7'd4};
        step();
        push = '0; pop = 2'b11;
        #2 rst = 1'b1;
        #1;
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL mrst_count got %0d want 32", count); end
        checks++; if (pop_data[6:0] !== 7'd32) begin errors++; $display("FAIL mrst_pd0 got %0d want 32", pop_data[6:0]); end
        checks++; if (pop_data[13:7] !== 7'd33) begin errors++; $display("FAIL mrst_pd1 got %0d want 33", pop_data[13:7]); end
        checks++; if (valid !== 2'b11) begin errors++; $display("FAIL mrst_valid got %b want 11", valid); end
        step();
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL mrst_hold got %0d want 32", count); end
        pop = '0; rst = 1'b0;
        step();
        checks++; if (count !== 7'd32) begin errors++; $display("FAIL mrst_release got %0d want 32", count); end
        checks++; if (pop_data[6:0] !== 7'd32) begin errors++; $display("FAIL mrst_release_pd0 got %0d want 32", pop_data[6:0]); end
    endtask

`ifdef FREE_LIST_MP_CKPT_EN
    task automatic test_ckpt();
        pop = 2'b11; step(); step(); pop = '0;
        ckpt_save = 1'b1; step(); ckpt_save = 1'b0;
        checks++; if (count !== 7'd28) begin errors++; $display("FAIL ckpt_save_count got %0d want 28", count); end
        checks++; if (pop_data[6:0] !== 7'd36) begin errors++; $display("FAIL ckpt_save_pd0 got %0d want 36", pop_data[6:0]); end
        pop = 2'b11; step(); step(); step(); pop = '0;
        checks++; if (count !== 7'd22) begin errors++; $display("FAIL ckpt_pop6_count got %0d want 22", count); end
        checks++; if (pop_data[6:0] !== 7'd42) begin errors++; $display("FAIL ckpt_pop6_pd0 got %0d want 42", pop_data[6:0]); end
        ckpt_restore = 1'b1; push = 2'b01; push_data = {7'd0, 7'd5};
        step();
        ckpt_restore = 1'b0; push = '0;
        checks++; if (count !== 7'd29) begin errors++; $display("FAIL ckpt_restore_count got %0d want 29", count); end
        checks++; if (pop_data[6:0] !== 7'd36) begin errors++; $display("FAIL ckpt_restore_pd0 got %0d want 36", pop_data[6:0]); end
        pop = 2'b11; step(); pop = '0;
        ckpt_save = 1'b1; ckpt_restore = 1'b1;
        step();
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        checks++; if (count !== 7'd29) begin errors++; $display("FAIL ckpt_both_count got %0d want 29", count); end
        pop = 2'b11; step(); pop = '0;
        checks++; if (pop_data[6:0] !== 7'd38) begin errors++; $display("FAIL ckpt_both_pd0 got %0d want 38", pop_data[6:0]); end
        ckpt_restore = 1'b1; step(); ckpt_restore = 1'b0;
        checks++; if (count !== 7'd29) begin errors++; $display("FAIL ckpt_unchanged_count got %0d want 29", count); end
        checks++; if (pop_data[6:0] !== 7'd36) begin errors++; $display("FAIL ckpt_unchanged_pd0 got %0d want 36", pop_data[6:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_pop_drain();
        test_no_bypass();
        test_push_port1();
        test_fill();
        test_wrap();
        test_mid_reset();
`ifdef FREE_LIST_MP_CKPT_EN
        test_ckpt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list_mp.md
Name: free_list_mp

Overview:
- Multi-ported, initialised circular FIFO used as the rename-stage free list, generalised to any width and depth.
- At reset it is preloaded with identifiers INIT_BASE..INIT_BASE+INIT_COUNT-1.
- Per cycle it supplies up to POP_PORTS identifiers to rename and reclaims up to PUSH_PORTS identifiers from commit.
- Sits between rename allocation and commit release.

Parameters:
- DW, 7, identifier width.
- DEPTH, 64, number of slots; power of two, >= max(PUSH_PORTS, POP_PORTS).
- PUSH_PORTS, 2, release ports per cycle.
- POP_PORTS, 2, allocation ports per cycle.
- INIT_BASE, 32, value loaded into slot 0 at reset; slot i gets INIT_BASE+i, truncated to DW.
- INIT_COUNT, 32, occupied slots after reset; <= DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- push  in  PUSH_PORTS  per-port release strobe; any bit pattern allowed.
- push_data  in  PUSH_PORTS*DW  released identifiers.
- ready  out  1  free slots >= PUSH_PORTS.
- pop  in  POP_PORTS  allocation strobes; must be thermometer from bit 0.
- pop_data  out  POP_PORTS*DW  identifiers offered, oldest on port 0.
- valid  out  POP_PORTS  valid[i] = occupancy > i.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Pointers and occupancy:
  - head and tail are binary, log2(DEPTH)+1 bits wide (MSB is the wrap bit).
  - count = tail - head, modulo 2^(log2(DEPTH)+1).
- Reset values:
  - mem[i] = INIT_BASE+i for all i < DEPTH.
  - head = 0; tail = INIT_COUNT.
  - Hence count = INIT_COUNT.
  - valid[i] = (INIT_COUNT > i).
  - ready = (DEPTH-INIT_COUNT >= PUSH_PORTS).
  - pop_data[i] = INIT_BASE+i.
- Pop path:
  - Combinational, zero latency: pop_data[i] = mem[(head+i) mod DEPTH].
  - npop = popcount(pop); head advances by npop at the clock edge.
- Push path:
  - Active pushes are compacted in port order.
  - The k-th active push writes mem[(tail+k) mod DEPTH].
  - tail advances by npush. Write latency is 1 cycle.
- No bypass: data pushed in cycle t is poppable from cycle t+1 at the earliest.
- Simultaneous push and pop: both are applied; count_next = count + npush - npop.
- Push and pop never touch the same slot in the same cycle, because a pop requires an occupied slot and a push requires a free slot.
- Wrap-around: slot index is the pointer's low bits; the wrap bit distinguishes full from empty.
  - Full: count = DEPTH.
  - Empty: count = 0.
- Assertions (simulation only, disabled during rst, $fatal):
  - push != 0 implies ready.
  - pop[i] implies valid[i].
  - pop is thermometer-coded.
- Reset mid-operation: immediate return to the reset state above; in-flight strobes are discarded.

Optional Feature:
- Macro: FREE_LIST_MP_CKPT_EN. Adds two input ports, ckpt_save (1 bit) and ckpt_restore (1 bit), plus a checkpoint head register ckpt_head.
- ckpt_save: ckpt_head <= head_next, i.e. the head after this cycle's pops.
- ckpt_restore: head <= ckpt_head.
  - Pushes in the same cycle are still applied.
  - pop must be 0 in that cycle (asserted).
  - count recomputes from the pointers automatically.
- Save and restore in the same cycle: restore wins; ckpt_head is unchanged.
- ckpt_head resets to 0.
- Without the macro: neither port exists; no checkpoint register.

Decomposition:
- Package free_list_pkg holds:
  - the pointer typedef, log2(DEPTH)+1 bits;
  - a popcount function;
  - a push-compaction offset function (prefix count of push bits below port k).
- One sub-module, fl_onehot_dec: converts a binary index to a one-hot DEPTH-wide select.
  - Instantiated per pop port, feeding the shared and_or_mux.
  - Instantiated per push port for the write enables.

Test Plan:
- Reset default, DEPTH=64/INIT_BASE=32/INIT_COUNT=32 -> count=32, pop_data={33,32}, valid=2'b11, ready=1.
- Pop 2/cycle for 16 cycles -> identifiers 32..63 in order; then count=0, valid=2'b00; a further pop fires the assertion.
- Push {5,9} with push=2'b10 (port 1 only) -> one slot filled; count +1; next pop_data[0]=9.
- Fill to count=63 -> ready=0. Pop 1 and push 1 with count=40 -> count stays 40; tail wraps past slot 63 correctly.
- Push at cycle t with count=0 -> valid[0]=0 in cycle t, valid[0]=1 in t+1 (no bypass).
- With FREE_LIST_MP_CKPT_EN:
  - save at head=4, pop 6 identifiers, then restore while pushing 1 -> head=4 and count = previous count + 6 + 1;
  - restore and save together -> ckpt_head unchanged.
